// File: rtl/instr_fetch_sequencer_if.sv
// instr_fetch_sequencer_if: instruction-memory req/ack fetch bundle
interface instr_fetch_sequencer_if #(parameter int ADDR_W = 32);
  logic req;
  logic [ADDR_W-1:0] addr;
  logic [31:0] rdata;
  logic ack;
  modport master(output req, addr, input rdata, ack);
  modport slave(input req, addr, output rdata, ack);
endinterface

// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: PC, IR and stage register with req/ack instruction fetch and retire-time PC update
module instr_fetch_sequencer #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic reset,
  instr_fetch_sequencer_if.master imem,
  input  logic [2:0] next_state,
  input  logic [1:0] PC_src,
  input  logic [ADDR_W-1:0] ret_addr,
  input  logic mem_wait,
  output logic [2:0] state,
  output logic [5:0] opcode,
  output logic [1:0] mode,
  output logic [15:0] imm16,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic [31:0] instr_retired
);
  typedef enum logic [2:0] {IF_S, ID_S, EX_S, MEM_S, WB_S} stage_t;
  logic [2:0] st, nxt;
  logic [31:0] ir;
  logic req;
  logic [ADDR_W-1:0] simm, target;
  assign state = st;
  assign opcode = ir[31:26];
  assign mode = ir[1:0];
  assign imm16 = ir[17:2];
  assign imem.req = req;
  assign imem.addr = pc;
  assign simm = {{(ADDR_W-16){ir[17]}}, ir[17:2]};
  always_comb begin
    nxt = (st == MEM_S && mem_wait) ? MEM_S : next_state;
    target = PC_src == 2'b00 ? pc_plus1 :
             PC_src == 2'b01 ? {pc_plus1[ADDR_W-1:26], ir[25:0]} :
             PC_src == 2'b10 ? pc_plus1 + simm : ret_addr;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IF_S;
      pc <= RESET_PC;
      pc_plus1 <= RESET_PC + ADDR_W'(1);
      ir <= '0;
      req <= 1'b0;
      instr_retired <= '0;
    end else if (st == IF_S) begin
      req <= ~(req & imem.ack);
      if (req && imem.ack) begin
        ir <= imem.rdata;
        pc_plus1 <= pc + ADDR_W'(1);
        st <= ID_S;
      end
    end else if (st > WB_S) begin
      st <= IF_S;
    end else begin
      st <= nxt;
      if (nxt == IF_S) begin
        pc <= target;
        instr_retired <= instr_retired + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb_instr_fetch_sequencer: directed self-checking bench for instr_fetch_sequencer
module tb_instr_fetch_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic [2:0] next_state;
  logic [1:0] PC_src;
  logic [31:0] ret_addr;
  logic mem_wait;
  logic [2:0] state;
  logic [5:0] opcode;
  logic [1:0] mode;
  logic [15:0] imm16;
  logic [31:0] pc, pc_plus1, instr_retired;
  logic [31:0] exp_ret;
  int total = 0;
  int bad = 0;
  instr_fetch_sequencer_if #(.ADDR_W(32)) imem();
  instr_fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem(imem), .next_state(next_state), .PC_src(PC_src),
    .ret_addr(ret_addr), .mem_wait(mem_wait), .state(state), .opcode(opcode), .mode(mode),
    .imm16(imm16), .pc(pc), .pc_plus1(pc_plus1), .instr_retired(instr_retired)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [31:0] instr, input logic [31:0] at);
    total++; if (state !== 3'd0 || imem.req !== 1'b0) begin bad++; $display("FAIL fetch_entry state=%0d req=%0b want 0/0", state, imem.req); end
    step();
    total++; if (imem.req !== 1'b1 || imem.addr !== at) begin bad++; $display("FAIL fetch_req req=%0b addr=%h want 1/%h", imem.req, imem.addr, at); end
    step();
    total++; if (imem.req !== 1'b1 || imem.addr !== at || state !== 3'd0) begin bad++; $display("FAIL fetch_hold req=%0b addr=%h state=%0d want 1/%h/0", imem.req, imem.addr, state, at); end
    imem.ack = 1'b1;
    imem.rdata = instr;
    step();
    imem.ack = 1'b0;
    imem.rdata = '0;
    total++; if (state !== 3'd1 || imem.req !== 1'b0 || opcode !== instr[31:26] || pc_plus1 !== at + 32'd1) begin bad++; $display("FAIL fetch_done state=%0d req=%0b op=%h pc1=%h want 1/0/%h/%h", state, imem.req, opcode, pc_plus1, instr[31:26], at + 32'd1); end
  endtask
  task automatic go(input logic [2:0] ns);
    next_state = ns;
    step();
    total++; if (state !== ns) begin bad++; $display("FAIL go state=%0d want %0d", state, ns); end
  endtask
  task automatic retire(input logic [1:0] src, input logic [31:0] ra, input logic [31:0] want_pc);
    PC_src = src;
    ret_addr = ra;
    next_state = 3'd0;
    step();
    exp_ret = exp_ret + 32'd1;
    total++; if (state !== 3'd0 || pc !== want_pc || instr_retired !== exp_ret || imem.req !== 1'b0) begin bad++; $display("FAIL retire state=%0d pc=%h cnt=%h req=%0b want 0/%h/%h/0", state, pc, instr_retired, imem.req, want_pc, exp_ret); end
  endtask
  task automatic test_reset();
    reset = 1'b1; next_state = 3'd0; PC_src = 2'b00; ret_addr = '0; mem_wait = 1'b0;
    imem.ack = 1'b0; imem.rdata = '0; exp_ret = '0;
    step();
    step();
    total++; if (state !== 3'd0 || pc !== 32'd0 || imem.req !== 1'b0 || instr_retired !== 32'd0 || pc_plus1 !== 32'd1) begin bad++; $display("FAIL reset_vals state=%0d pc=%h req=%0b cnt=%h pc1=%h want 0/0/0/0/1", state, pc, imem.req, instr_retired, pc_plus1); end
    reset = 1'b0;
    step();
    total++; if (imem.req !== 1'b1 || imem.addr !== 32'd0 || state !== 3'd0) begin bad++; $display("FAIL reset_release req=%0b addr=%h state=%0d want 1/0/0", imem.req, imem.addr, state); end
  endtask
  task automatic test_alu();
    imem.ack = 1'b1;
    imem.rdata = 32'h0000_0000;
    step();
    imem.ack = 1'b0;
    total++; if (state !== 3'd1 || imem.req !== 1'b0 || opcode !== 6'd0) begin bad++; $display("FAIL alu_id state=%0d req=%0b op=%h want 1/0/0", state, imem.req, opcode); end
    go(3'd2);
    go(3'd4);
    retire(2'b00, 32'h0000_0BAD, 32'd1);
  endtask
  task automatic test_stall();
    fetch({6'b000101, 26'd0}, 32'd1);
    go(3'd2);
    go(3'd3);
    mem_wait = 1'b1;
    next_state = 3'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (state !== 3'd3) begin bad++; $display("FAIL stall_hold%0d state=%0d want 3", i, state); end
    end
    mem_wait = 1'b0;
    step();
    total++; if (state !== 3'd4) begin bad++; $display("FAIL stall_release state=%0d want 4", state); end
    retire(2'b11, 32'd10, 32'd10);
  endtask
  task automatic test_branch();
    fetch(32'h1003_FFF0, 32'd10);
    total++; if (imm16 !== 16'hFFFC || mode !== 2'b00) begin bad++; $display("FAIL br_neg_fields imm=%h mode=%0d want fffc/0", imm16, mode); end
    go(3'd2);
    retire(2'b10, 32'h0000_0BAD, 32'd7);
    fetch(32'h0C00_0000, 32'd7);
    retire(2'b11, 32'd10, 32'd10);
    fetch(32'h1000_0015, 32'd10);
    total++; if (imm16 !== 16'h0005 || mode !== 2'b01) begin bad++; $display("FAIL br_pos_fields imm=%h mode=%0d want 0005/1", imm16, mode); end
    go(3'd2);
    retire(2'b10, 32'h0000_0BAD, 32'd16);
  endtask
  task automatic test_jump_return();
    fetch(32'h0800_0040, 32'd16);
    retire(2'b01, 32'h0000_0BAD, 32'h40);
    fetch(32'h0C00_0000, 32'h40);
    retire(2'b11, 32'h1234, 32'h1234);
  endtask
  task automatic test_edges();
    fetch(32'h0000_0000, 32'h1234);
    go(3'd7);
    next_state = 3'd0;
    step();
    total++; if (state !== 3'd0 || pc !== 32'h1234 || instr_retired !== exp_ret || imem.req !== 1'b0) begin bad++; $display("FAIL illegal state=%0d pc=%h cnt=%h req=%0b want 0/1234/%h/0", state, pc, instr_retired, exp_ret, imem.req); end
    imem.ack = 1'b1;
    imem.rdata = 32'hFFFF_FFFF;
    step();
    total++; if (state !== 3'd0 || imem.req !== 1'b1 || opcode !== 6'd0) begin bad++; $display("FAIL ack_no_req state=%0d req=%0b op=%h want 0/1/0", state, imem.req, opcode); end
    reset = 1'b1;
    imem.rdata = 32'hDEAD_BEEF;
    step();
    total++; if (imem.req !== 1'b0 || state !== 3'd0 || opcode !== 6'd0 || imm16 !== 16'd0 || mode !== 2'd0 || pc !== 32'd0) begin bad++; $display("FAIL reset_mid_fetch req=%0b state=%0d op=%h imm=%h mode=%0d pc=%h want all 0", imem.req, state, opcode, imm16, mode, pc); end
    reset = 1'b0;
    imem.ack = 1'b0;
    exp_ret = '0;
    total++; if (instr_retired !== 32'd0) begin bad++; $display("FAIL reset_cnt cnt=%h want 0", instr_retired); end
  endtask
  task automatic test_wrap();
    fetch(32'h0000_0000, 32'd0);
    force dut.instr_retired = 32'hFFFF_FFFF;
    #1;
    release dut.instr_retired;
    exp_ret = 32'hFFFF_FFFF;
    go(3'd2);
    retire(2'b00, 32'h0000_0BAD, 32'd1);
  endtask
  initial begin
    test_reset();
    test_alu();
    test_stall();
    test_branch();
    test_jump_return();
    test_edges();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
